// File: rtl/ball_motion.sv
// Pong ball position engine: steps, wall/paddle bounces, misses, score pulses.
// Optional feature macro: BALL_SPEEDUP_EN (step period shrinks every 4 paddle hits).
module ball_motion #(
  parameter int SCREEN_W     = 640,
  parameter int SCREEN_H     = 480,
  parameter int BALL_SIZE    = 8,
  parameter int PADDLE_H     = 64,
  parameter int PADDLE_W     = 8,
  parameter int PADDLE_X_L   = 16,
  parameter int PADDLE_X_R   = 616,
  parameter int TICKS_PER_PX = 4,
  parameter int HOLD_CYCLES  = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               game_on,
  input  logic               serve,
  input  logic signed [31:0] left_paddle_y,
  input  logic signed [31:0] right_paddle_y,
  output logic signed [31:0] ball_x,
  output logic signed [31:0] ball_y,
  output logic               dir_right,
  output logic               dir_down,
  output logic               in_play,
  output logic               score_left,
  output logic               score_right
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_MOVING = 2'd1;
  localparam logic [1:0] S_SCORED = 2'd2;

  localparam int X_C   = (SCREEN_W - BALL_SIZE) / 2;
  localparam int Y_C   = (SCREEN_H - BALL_SIZE) / 2;
  localparam int X_MAX = SCREEN_W - BALL_SIZE;
  localparam int Y_MAX = SCREEN_H - BALL_SIZE;
  localparam int X_HL  = PADDLE_X_L + PADDLE_W;

  localparam logic [31:0] TPP  = 32'(TICKS_PER_PX);
  localparam logic [31:0] HOLD = 32'(HOLD_CYCLES);

  logic [1:0]         state_q, state_d;
  logic signed [31:0] x_q, x_d;
  logic signed [31:0] y_q, y_d;
  logic               dr_q, dr_d;
  logic               dd_q, dd_d;
  logic [31:0]        tick_q, tick_d;
  logic [31:0]        hold_q, hold_d;
  logic               sl_q, sl_d;
  logic               sr_q, sr_d;
  logic               step;
  logic [31:0]        tpp;

  logic ovl_l, ovl_r;
  logic hit_l, hit_r;
  logic miss_l, miss_r;

`ifdef BALL_SPEEDUP_EN
  logic [2:0]  hits_q, hits_d;
  logic [31:0] tpp_q, tpp_d;
  assign tpp = tpp_q;
`else
  assign tpp = TPP;
`endif

  // Paddle overlap and edge conditions on the current registered position.
  assign ovl_l  = (y_q + BALL_SIZE > left_paddle_y) &&
                  (y_q < left_paddle_y + PADDLE_H);
  assign ovl_r  = (y_q + BALL_SIZE > right_paddle_y) &&
                  (y_q < right_paddle_y + PADDLE_H);
  assign hit_l  = !dr_q && (x_q == X_HL) && ovl_l;
  assign hit_r  = dr_q && (x_q + BALL_SIZE == PADDLE_X_R) && ovl_r;
  assign miss_l = !dr_q && (x_q == 0);
  assign miss_r = dr_q && (x_q == X_MAX);

  // Next-state: serve, tick/step, miss handling and post-point hold.
  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    dr_d    = dr_q;
    dd_d    = dd_q;
    tick_d  = tick_q;
    hold_d  = hold_q;
    sl_d    = 1'b0;
    sr_d    = 1'b0;
    step    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (serve && game_on) begin
          state_d = S_MOVING;
          dd_d    = 1'b1;
          tick_d  = 32'd0;
        end
      end
      S_MOVING: begin
        if (game_on) begin
          if (tick_q >= tpp - 32'd1) begin
            tick_d = 32'd0;
            step   = 1'b1;
          end else begin
            tick_d = tick_q + 32'd1;
          end
        end
        if (step) begin
          if (miss_l || miss_r) begin
            state_d = S_SCORED;
            hold_d  = 32'd0;
            sr_d    = miss_l;
            sl_d    = miss_r;
            dr_d    = miss_r;
          end else begin
            if (!dd_q && y_q == 0) begin
              dd_d = 1'b1;
              y_d  = 32'sd1;
            end else if (dd_q && y_q == Y_MAX) begin
              dd_d = 1'b0;
              y_d  = y_q - 32'sd1;
            end else begin
              y_d  = dd_q ? y_q + 32'sd1 : y_q - 32'sd1;
            end
            if (hit_l) begin
              dr_d = 1'b1;
              x_d  = x_q + 32'sd1;
            end else if (hit_r) begin
              dr_d = 1'b0;
              x_d  = x_q - 32'sd1;
            end else begin
              x_d  = dr_q ? x_q + 32'sd1 : x_q - 32'sd1;
            end
          end
        end
      end
      S_SCORED: begin
        if (game_on) begin
          if (hold_q >= HOLD - 32'd1) begin
            state_d = S_IDLE;
            x_d     = X_C;
            y_d     = Y_C;
          end else begin
            hold_d = hold_q + 32'd1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

`ifdef BALL_SPEEDUP_EN
  // Every 4th paddle hit shortens the step period, floored at one cycle.
  always_comb begin
    hits_d = hits_q;
    tpp_d  = tpp_q;
    if (state_d == S_IDLE && state_q != S_IDLE) begin
      hits_d = 3'd0;
      tpp_d  = TPP;
    end else if (step && (hit_l || hit_r)) begin
      if (hits_q == 3'd3) begin
        hits_d = 3'd0;
        if (tpp_q > 32'd1) tpp_d = tpp_q - 32'd1;
      end else begin
        hits_d = hits_q + 3'd1;
      end
    end
  end

  // Speed-up state registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hits_q <= 3'd0;
      tpp_q  <= TPP;
    end else begin
      hits_q <= hits_d;
      tpp_q  <= tpp_d;
    end
  end
`endif

  // Main state registers; reset drops any point in progress silently.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      x_q     <= X_C;
      y_q     <= Y_C;
      dr_q    <= 1'b1;
      dd_q    <= 1'b1;
      tick_q  <= 32'd0;
      hold_q  <= 32'd0;
      sl_q    <= 1'b0;
      sr_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      dr_q    <= dr_d;
      dd_q    <= dd_d;
      tick_q  <= tick_d;
      hold_q  <= hold_d;
      sl_q    <= sl_d;
      sr_q    <= sr_d;
    end
  end

  assign ball_x      = x_q;
  assign ball_y      = y_q;
  assign dir_right   = dr_q;
  assign dir_down    = dd_q;
  assign in_play     = (state_q == S_MOVING);
  assign score_left  = sl_q;
  assign score_right = sr_q;

endmodule

// File: tb/tb_ball_motion.sv
// Scoreboard bench for ball_motion: every output change is an event;
// hand-computed expectations are keyed by event index since reset.
module tb_ball_motion;

  logic               clk;
  logic               reset;
  logic               game_on;
  logic               serve;
  logic signed [31:0] left_paddle_y;
  logic signed [31:0] right_paddle_y;
  logic signed [31:0] ball_x;
  logic signed [31:0] ball_y;
  logic               dir_right;
  logic               dir_down;
  logic               in_play;
  logic               score_left;
  logic               score_right;

  ball_motion dut (
    .clk            (clk),
    .reset          (reset),
    .game_on        (game_on),
    .serve          (serve),
    .left_paddle_y  (left_paddle_y),
    .right_paddle_y (right_paddle_y),
    .ball_x         (ball_x),
    .ball_y         (ball_y),
    .dir_right      (dir_right),
    .dir_down       (dir_down),
    .in_play        (in_play),
    .score_left     (score_left),
    .score_right    (score_right)
  );

  typedef struct {
    int idx;
    int gap;
    int x;
    int y;
    bit dr;
    bit dd;
    bit ip;
    bit sl;
    bit sr;
  } exp_t;

  exp_t sbq[$];
  int   checks = 0;
  int   errors = 0;
  int   evt    = -1;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic push(input int idx, input int gap, input int x,
                      input int y, input bit dr, input bit dd,
                      input bit ip, input bit sl, input bit sr);
    exp_t e;
    e.idx = idx; e.gap = gap; e.x = x; e.y = y;
    e.dr = dr; e.dd = dd; e.ip = ip; e.sl = sl; e.sr = sr;
    sbq.push_back(e);
  endtask

  // Monitor: detects output events at the falling edge and scores them.
  initial begin
    logic [68:0] cur;
    logic [68:0] prev;
    bit          in_rst;
    bit          fire;
    int          cyc;
    int          last_cyc;
    int          gap;
    exp_t        e;
    in_rst   = 1'b0;
    cyc      = 0;
    last_cyc = 0;
    prev     = '0;
    forever begin
      @(negedge clk);
      cyc++;
      cur = {ball_x, ball_y, dir_right, dir_down,
             in_play, score_left, score_right};
      if (reset) begin
        if (!in_rst) begin
          while (sbq.size() > 0) begin
            e = sbq.pop_front();
            checks++;
            errors++;
            $display("FAIL lost_evt%0d: got no event, want one before reset",
                     e.idx);
          end
        end
        in_rst = 1'b1;
        evt    = -1;
      end else begin
        fire = 1'b0;
        if (in_rst) begin
          fire   = 1'b1;
          in_rst = 1'b0;
        end else if (cur != prev) begin
          fire = 1'b1;
        end
        if (fire) begin
          evt++;
          gap      = cyc - last_cyc;
          last_cyc = cyc;
          while (sbq.size() > 0 && sbq[0].idx <= evt) begin
            e = sbq.pop_front();
            checks++;
            if (e.idx < evt) begin
              errors++;
              $display("FAIL skip_evt%0d: got event %0d first", e.idx, evt);
            end else if (ball_x != e.x || ball_y != e.y ||
                         dir_right != e.dr || dir_down != e.dd ||
                         in_play != e.ip || score_left != e.sl ||
                         score_right != e.sr ||
                         (e.gap >= 0 && gap != e.gap)) begin
              errors++;
              $display("FAIL evt%0d: got x=%0d y=%0d dr=%0b dd=%0b ip=%0b sl=%0b sr=%0b gap=%0d want x=%0d y=%0d dr=%0b dd=%0b ip=%0b sl=%0b sr=%0b gap=%0d",
                       evt, ball_x, ball_y, dir_right, dir_down, in_play,
                       score_left, score_right, gap, e.x, e.y, e.dr, e.dd,
                       e.ip, e.sl, e.sr, e.gap);
            end
          end
        end
      end
      prev = cur;
    end
  end

  // Stimulus: two points, a freeze window and a mid-play reset.
  initial begin
    reset          = 1'b1;
    game_on        = 1'b1;
    serve          = 1'b0;
    left_paddle_y  = 104;
    right_paddle_y = 380;
    repeat (3) @(negedge clk);
    // Point 1: right paddle return, top bounce, left paddle just missed.
    push(0,   -1, 316, 236, 1, 1, 0, 0, 0);
    push(1,   -1, 316, 236, 1, 1, 1, 0, 0);
    push(2,    4, 317, 237, 1, 1, 1, 0, 0);
    push(3,    4, 318, 238, 1, 1, 1, 0, 0);
    push(237,  4, 552, 472, 1, 1, 1, 0, 0);
    push(238,  4, 553, 471, 1, 0, 1, 0, 0);
    push(293,  4, 608, 416, 1, 0, 1, 0, 0);
    push(294,  4, 607, 415, 0, 0, 1, 0, 0);
    push(709,  4, 192,   0, 0, 0, 1, 0, 0);
    push(710,  4, 191,   1, 0, 1, 1, 0, 0);
    push(877,  4,  24, 168, 0, 1, 1, 0, 0);
    push(878,  4,  23, 169, 0, 1, 1, 0, 0);
    push(901,  4,   0, 192, 0, 1, 1, 0, 0);
    push(902,  4,   0, 192, 0, 1, 0, 0, 1);
    push(903,  1,   0, 192, 0, 1, 0, 0, 0);
    push(904, 15, 316, 236, 0, 1, 0, 0, 0);
    // Point 2: serve leftward, freeze, bottom bounce, left paddle edge hit.
    push(905,  -1, 316, 236, 0, 1, 1, 0, 0);
    push(906,   4, 315, 237, 0, 1, 1, 0, 0);
    push(907,  14, 314, 238, 0, 1, 1, 0, 0);
    push(1141,  4,  80, 472, 0, 1, 1, 0, 0);
    push(1142,  4,  79, 471, 0, 0, 1, 0, 0);
    push(1197,  4,  24, 416, 0, 0, 1, 0, 0);
    push(1198,  4,  25, 415, 1, 0, 1, 0, 0);
    push(1199,  4,  26, 414, 1, 0, 1, 0, 0);
    @(negedge clk); #2 reset = 1'b0;
    @(negedge clk); #2 serve = 1'b1;
    @(negedge clk); #2 serve = 1'b0;
    repeat (3630) @(negedge clk);
    #2 serve = 1'b1;
    left_paddle_y = 423;
    @(negedge clk); #2 serve = 1'b0;
    repeat (5) @(negedge clk);
    #2 game_on = 1'b0;
    repeat (10) @(negedge clk);
    #2 game_on = 1'b1;
    repeat (1173) @(negedge clk);
    #2 reset = 1'b1;
    repeat (3) @(negedge clk);
    push(0, -1, 316, 236, 1, 1, 0, 0, 0);
    #2 reset = 1'b0;
    repeat (30) @(negedge clk);
    checks++;
    if (sbq.size() != 0) begin
      errors++;
      $display("FAIL pending: got %0d unmatched, want 0", sbq.size());
    end
    checks++;
    if (evt != 0) begin
      errors++;
      $display("FAIL quiet_after_reset: got last event %0d, want 0", evt);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
